// File: rtl/rdclk_fifo_pkg.sv
// Shared constants and helpers for the rdclk-domain FWFT FIFO.
// Holds the default geometry, the pointer-width helper and the depth sanity check.
package rdclk_fifo_pkg;

    localparam int DEF_WIDTH     = 1;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_AFULL_LVL = 6;

    // Encoded as {push accepted, pop accepted} so the top can cast directly.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit depth_is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/rdclk_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
// The asynchronous read is what gives the FIFO its first-word-fall-through head.
(* whitebox *)
module rdclk_fifo_mem
    import rdclk_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = fifo_ptr_w(DEPTH)
) (
    input  logic             rdclk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    // Contents are deliberately never cleared; occupancy tracking makes stale words unreachable.
    always_ff @(posedge rdclk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/rdclk_fifo.sv
// Single-clock FWFT FIFO feeding the rdclk consumer: pointers, occupancy,
// registered status flags and sticky overflow/underflow error bits.
module rdclk_fifo
    import rdclk_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_LVL = DEF_AFULL_LVL
) (
    input  logic                     rdclk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(AFULL_LVL);

    generate
        if (!depth_is_pow2(DEPTH)) begin : g_bad_depth
            $error("rdclk_fifo: DEPTH must be a power of two and at least 2");
        end
        if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
            $error("rdclk_fifo: AFULL_LVL must lie in 1..DEPTH");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             full_reg, empty_reg, almost_full_reg;
    logic             overflow_reg, underflow_reg;
    logic             push_ok, pop_ok, push_rejected, pop_rejected;
    fifo_op_e         op;

    // A full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        push_ok       = wr_en && (!full_reg || rd_en);
        pop_ok        = rd_en && !empty_reg;
        push_rejected = wr_en && full_reg && !rd_en;
        pop_rejected  = rd_en && empty_reg;
        op            = fifo_op_e'({push_ok, pop_ok});
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        case (op)
            OP_PUSH: begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                count_next  = count_reg + CNT_ONE;
            end
            OP_POP: begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
                count_next  = count_reg - CNT_ONE;
            end
            OP_BOTH: begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            default: ;
        endcase
    end

    // Flags are computed from the post-edge count so no enable reaches them combinationally.
    always_ff @(posedge rdclk) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            empty_reg       <= 1'b1;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            empty_reg       <= (count_next == '0);
            full_reg        <= (count_next == CNT_DEPTH);
            almost_full_reg <= (count_next >= CNT_AFULL);
            overflow_reg    <= overflow_reg | push_rejected;
            underflow_reg   <= underflow_reg | pop_rejected;
        end
    end

    rdclk_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .rdclk (rdclk),
        .we    (push_ok && !rst),
        .waddr (wr_ptr_reg),
        .wdata (wr_data),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

    assign full        = full_reg;
    assign almost_full = almost_full_reg;
    assign empty       = empty_reg;
    assign count       = count_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;

endmodule
